// File: rtl/pmem_burst_initiator.sv
// Physical-memory burst initiator: turns whole-line read/write requests from the
// last-level cache into BURST_LEN-beat bursts qualified by pmem_resp.
module pmem_burst_initiator #(
  parameter int unsigned CACHE_LINE_WIDTH = 256,
  parameter int unsigned BURST_LEN        = 4,
  parameter int unsigned TIMEOUT          = 1024,
  localparam int unsigned BURST_WIDTH     = CACHE_LINE_WIDTH / BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        line_read_i,
  input  logic                        line_write_i,
  input  logic [31:0]                 line_addr_i,
  input  logic [CACHE_LINE_WIDTH-1:0] line_wdata_i,
  output logic [CACHE_LINE_WIDTH-1:0] line_rdata_o,
  output logic                        line_resp_o,
  output logic                        error_o,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_address,
  output logic [BURST_WIDTH-1:0]      pmem_wdata,
  input  logic [BURST_WIDTH-1:0]      pmem_rdata,
  input  logic                        pmem_resp
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ADDR_MASK = ~(32'(CACHE_LINE_WIDTH / 8) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t                      state, state_n;
  logic [CNT_W-1:0]            cnt;
  logic [TO_W-1:0]             tcnt;
  logic [CACHE_LINE_WIDTH-1:0] wline;
  logic                        last_beat;
  logic                        timed_out;
  logic                        accept;

  assign accept    = (state == IDLE) && (line_read_i || line_write_i);
  assign last_beat = pmem_resp && (cnt == CNT_W'(BURST_LEN - 1));
  assign timed_out = (tcnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (line_write_i)     state_n = WR_BURST;
        else if (line_read_i) state_n = RD_BURST;
      end
      RD_BURST, WR_BURST: begin
        if (last_beat || timed_out) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      tcnt         <= '0;
      wline        <= '0;
      line_rdata_o <= '0;
      line_resp_o  <= 1'b0;
      error_o      <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      line_resp_o <= 1'b0;
      if (accept) begin
        pmem_address <= line_addr_i & ADDR_MASK;
        wline        <= line_wdata_i;
        pmem_wdata   <= line_wdata_i[BURST_WIDTH-1:0];
        cnt          <= '0;
        tcnt         <= '0;
        pmem_write   <= line_write_i;
        pmem_read    <= ~line_write_i;
      end
      if (state == RD_BURST || state == WR_BURST) begin
        if (pmem_resp) begin
          if (state == RD_BURST)
            line_rdata_o[BURST_WIDTH*cnt +: BURST_WIDTH] <= pmem_rdata;
          else if (!last_beat)
            // next write beat is staged so it is on the bus right after the accepting edge
            pmem_wdata <= wline[BURST_WIDTH*(32'(cnt) + 32'd1) +: BURST_WIDTH];
          cnt <= cnt + CNT_W'(1);
        end
        if (last_beat || timed_out) begin
          pmem_read   <= 1'b0;
          pmem_write  <= 1'b0;
          line_resp_o <= 1'b1;
          if (!last_beat) error_o <= 1'b1;
        end else begin
          tcnt <= tcnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/pmem_burst_initiator.md
# pmem_burst_initiator

Initiator side of the physical-memory burst interface. Accepts whole-cache-line read/write requests from the last-level cache and turns them into BURST_LEN-beat bursts toward physical memory: hold read/write and address steady, transfer one beat per clock in which pmem_resp is high, then release. Sits between the L2/arbiter and the pmem port of the top level.

## Interface
- CACHE_LINE_WIDTH, 256, line size in bits
- BURST_LEN, 4, beats per line; BURST_WIDTH = CACHE_LINE_WIDTH/BURST_LEN (64)
- TIMEOUT, 1024, max cycles in a burst state before abort; must be > 0
- clk  in  1  clock; single clock domain (one clock; reset is asynchronous and active-low)
- rst  in  1  asynchronous active-low reset
- line_read_i  in  1  cache read request, held until line_resp_o
- line_write_i  in  1  cache write request, held until line_resp_o
- line_addr_i  in  32  byte address; low $clog2(CACHE_LINE_WIDTH/8) bits ignored
- line_wdata_i  in  CACHE_LINE_WIDTH  line to write, sampled at acceptance
- line_rdata_o  out  CACHE_LINE_WIDTH  assembled read line, valid while line_resp_o=1
- line_resp_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky timeout flag
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  32  line-aligned address
- pmem_wdata  out  BURST_WIDTH  current write beat
- pmem_rdata  in  BURST_WIDTH  current read beat
- pmem_resp  in  1  beat-transfer qualifier

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE. All outputs registered.
- IDLE: on edge with line_write_i=1 -> WR_BURST (write wins if both high); else line_read_i=1 -> RD_BURST. At acceptance latch address with low offset bits zeroed, latch line_wdata_i, clear beat counter and timeout counter.
- RD_BURST: pmem_read=1, pmem_write=0. Each edge with pmem_resp=1 stores pmem_rdata into line_rdata_o[BURST_WIDTH*cnt +: BURST_WIDTH], cnt++. Edge storing beat BURST_LEN-1 -> DONE.
- WR_BURST: pmem_write=1, pmem_read=0, pmem_wdata = latched line[BURST_WIDTH*cnt +: BURST_WIDTH] (beat 0 present from first cycle). Each edge with pmem_resp=1 counts as beat cnt accepted by memory, cnt++. Last beat -> DONE.
- pmem_resp low mid-burst (gap): hold beat, wait; no error.
- DONE: pmem_read=pmem_write=0, line_resp_o=1 for exactly one cycle, -> IDLE. Requester deasserts its request in the cycle after line_resp_o.
- pmem_address constant from acceptance through last beat; pmem_read/pmem_write never both high.
- Timeout: counter increments each cycle in RD_BURST/WR_BURST; reaching TIMEOUT -> DONE with line_resp_o pulse, error_o set until reset; line_rdata_o contents undefined on abort.
- pmem_resp while in IDLE/DONE ignored.

## Timing
- Reset (async, immediate): state IDLE, cnt 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, line_rdata_o 0, line_resp_o 0, error_o 0. Reset mid-burst drops strobes without waiting for clk.
- Acceptance edge -> strobe high next cycle (1-cycle latency).
- Strobe stays high through the edge of the final beat and is low in the following cycle (DONE), guaranteeing >=1 idle cycle between bursts; back-to-back request accepted in cycle after DONE.
- Total latency = 1 (accept) + memory latency + BURST_LEN beats + 1 (DONE).
- Counter width $clog2(BURST_LEN)+1; timeout counter width $clog2(TIMEOUT+1); no wrap within a burst.

## Test plan
- Read, addr 0x0000_1234, memory delay 10, beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address 0x0000_1220 steady, line_rdata_o = {0x44..,0x33..,0x22..,0x11..}, single line_resp_o pulse, pmem_read low in DONE.
- Write, line = {D3,D2,D1,D0} -> pmem_wdata shows D0 before first resp, D1/D2/D3 after each resp edge; memory captures D0..D3 in order; pmem_write never overlaps pmem_read.
- pmem_resp gaps (1,0,1,0,1,1) during read -> exactly 4 beats stored, correct order, no error_o.
- Back-to-back read then write with requests held high -> >=1 cycle both strobes low between bursts; address switches only after DONE.
- TIMEOUT=16, pmem_resp never asserted -> after 16 cycles strobe drops, line_resp_o pulses, error_o=1 and stays 1 until rst.
- rst asserted low mid write burst between clock edges -> pmem_write 0 immediately, all outputs at reset values; new read after release completes normally.
